// File: rtl/ddrx_pkg.sv
// Shared types for the DDR command scheduler: DRAM command codes, FSM states,
// arbitration grant owner and open-row lookup result.
package ddrx_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_PRE  = 3'd2,
        CMD_PREA = 3'd3,
        CMD_RD   = 3'd4,
        CMD_WR   = 3'd5,
        CMD_REF  = 3'd6
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_WAIT_RP,
        ST_ACTIVATE,
        ST_WAIT_RCD,
        ST_ACCESS,
        ST_WAIT_CCD,
        ST_REF_START,
        ST_WAIT_PREA,
        ST_REFRESH,
        ST_WAIT_RFC
    } sched_state_e;

    typedef enum logic {
        GRANT_READ,
        GRANT_WRITE
    } grant_e;

    typedef enum logic [1:0] {
        LOOKUP_HIT,
        LOOKUP_CLOSED,
        LOOKUP_CONFLICT
    } lookup_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddrx_bank_table.sv
// Open-row table: one open flag and one row address per bank, with a
// combinational lookup port and a single update port (ACT / PRE / clear-all).
module ddrx_bank_table
    import ddrx_pkg::*;
#(
    parameter int C_BANK_WIDTH = 3,
    parameter int C_ROW_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [C_BANK_WIDTH-1:0] i_lookup_bank,
    input  logic [C_ROW_WIDTH-1:0]  i_lookup_row,
    output lookup_e                 o_lookup,
    output logic                    o_any_open,
    input  logic                    i_act,
    input  logic                    i_pre,
    input  logic                    i_clear_all,
    input  logic [C_BANK_WIDTH-1:0] i_upd_bank,
    input  logic [C_ROW_WIDTH-1:0]  i_upd_row
);

    localparam int C_NUM_BANKS = 2 ** C_BANK_WIDTH;

    logic [C_NUM_BANKS-1:0] r_open;
    logic [C_ROW_WIDTH-1:0] r_row [C_NUM_BANKS];

    // Clear-all (PREA/REF) takes priority; ACT and PRE are never issued together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_open <= '0;
            for (int b = 0; b < C_NUM_BANKS; b++) begin
                r_row[b] <= '0;
            end
        end else if (i_clear_all) begin
            r_open <= '0;
        end else if (i_act) begin
            r_open[i_upd_bank] <= 1'b1;
            r_row[i_upd_bank]  <= i_upd_row;
        end else if (i_pre) begin
            r_open[i_upd_bank] <= 1'b0;
        end
    end

    always_comb begin
        o_lookup = LOOKUP_CLOSED;
        if (r_open[i_lookup_bank]) begin
            o_lookup = (r_row[i_lookup_bank] == i_lookup_row) ? LOOKUP_HIT : LOOKUP_CONFLICT;
        end
    end

    assign o_any_open = |r_open;

endmodule

// File: rtl/ddrx_cmd_scheduler.sv
// DRAM command scheduler: round-robin read/write arbitration with refresh
// priority, open-row tracking and timing-spaced ACT/PRE/PREA/RD/WR/REF issue.
module ddrx_cmd_scheduler
    import ddrx_pkg::*;
#(
    parameter int C_BANK_WIDTH = 3,
    parameter int C_ROW_WIDTH  = 16,
    parameter int C_COL_WIDTH  = 12,
    parameter int C_T_RCD      = 3,
    parameter int C_T_RP       = 3,
    parameter int C_T_RFC      = 8,
    parameter int C_T_CCD      = 2
) (
    input  logic                    core_clk,
    input  logic                    core_arst,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [C_BANK_WIDTH-1:0] rd_bank,
    input  logic [C_ROW_WIDTH-1:0]  rd_row,
    input  logic [C_COL_WIDTH-1:0]  rd_col,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [C_BANK_WIDTH-1:0] wr_bank,
    input  logic [C_ROW_WIDTH-1:0]  wr_row,
    input  logic [C_COL_WIDTH-1:0]  wr_col,
    input  logic                    ref_req,
    output logic                    ref_do,
    output logic                    cmd_valid,
    output cmd_e                    cmd_type,
    output logic [C_BANK_WIDTH-1:0] cmd_bank,
    output logic [C_ROW_WIDTH-1:0]  cmd_addr,
    output logic                    busy
);

    localparam int C_T_MAX = max_of(max_of(C_T_RCD, C_T_RP), max_of(C_T_RFC, C_T_CCD));
    localparam int C_CNT_W = (C_T_MAX > 1) ? $clog2(C_T_MAX) : 1;

    localparam logic [C_CNT_W-1:0] C_LD_RCD = C_CNT_W'(C_T_RCD - 1);
    localparam logic [C_CNT_W-1:0] C_LD_RP  = C_CNT_W'(C_T_RP - 1);
    localparam logic [C_CNT_W-1:0] C_LD_RFC = C_CNT_W'(C_T_RFC - 1);
    localparam logic [C_CNT_W-1:0] C_LD_CCD = C_CNT_W'(C_T_CCD - 1);

    sched_state_e              r_state, w_state_nxt;
    logic [C_CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [C_BANK_WIDTH-1:0]   r_bank;
    logic [C_ROW_WIDTH-1:0]    r_row;
    logic [C_COL_WIDTH-1:0]    r_col;
    logic                      r_is_write;
    lookup_e                   r_path;
    grant_e                    r_last_grant;

    logic                      r_cmd_valid;
    cmd_e                      r_cmd_type;
    logic [C_BANK_WIDTH-1:0]   r_cmd_bank;
    logic [C_ROW_WIDTH-1:0]    r_cmd_addr;
    logic                      r_ref_do;

    cmd_e                      w_cmd_nxt;
    logic [C_BANK_WIDTH-1:0]   w_bank_nxt;
    logic [C_ROW_WIDTH-1:0]    w_addr_nxt;
    logic                      w_issue_act;
    logic                      w_issue_col;
    logic                      w_issue_ref;

    logic                      w_idle;
    logic                      w_grant_rd;
    logic                      w_grant_wr;
    logic                      w_grant;
    logic [C_BANK_WIDTH-1:0]   w_req_bank;
    logic [C_ROW_WIDTH-1:0]    w_req_row;
    logic [C_COL_WIDTH-1:0]    w_req_col;
    lookup_e                   w_lookup;
    logic                      w_any_open;
    logic                      w_cnt_zero;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_grant_rd = w_idle && !core_arst && !ref_req && rd_valid &&
                        (!wr_valid || (r_last_grant == GRANT_WRITE));
    assign w_grant_wr = w_idle && !core_arst && !ref_req && wr_valid &&
                        (!rd_valid || (r_last_grant == GRANT_READ));
    assign w_grant    = w_grant_rd || w_grant_wr;
    assign w_req_bank = w_grant_wr ? wr_bank : rd_bank;
    assign w_req_row  = w_grant_wr ? wr_row  : rd_row;
    assign w_req_col  = w_grant_wr ? wr_col  : rd_col;
    assign w_cnt_zero = (r_cnt == '0);

    ddrx_bank_table #(
        .C_BANK_WIDTH (C_BANK_WIDTH),
        .C_ROW_WIDTH  (C_ROW_WIDTH)
    ) u_bank_table (
        .i_clk         (core_clk),
        .i_rst         (core_arst),
        .i_lookup_bank (w_req_bank),
        .i_lookup_row  (w_req_row),
        .o_lookup      (w_lookup),
        .o_any_open    (w_any_open),
        .i_act         (w_cmd_nxt == CMD_ACT),
        .i_pre         (w_cmd_nxt == CMD_PRE),
        .i_clear_all   ((w_cmd_nxt == CMD_PREA) || (w_cmd_nxt == CMD_REF)),
        .i_upd_bank    (w_bank_nxt),
        .i_upd_row     (w_addr_nxt)
    );

    // Commands are computed one cycle ahead and registered, so each issue
    // state is the cycle in which its command is visible. The counter is
    // loaded with T-1 alongside the command and counts down through the wait.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? '0 : r_cnt - C_CNT_W'(1);
        w_cmd_nxt   = CMD_NOP;
        w_bank_nxt  = '0;
        w_addr_nxt  = '0;
        w_issue_act = 1'b0;
        w_issue_col = 1'b0;
        w_issue_ref = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (ref_req) begin
                    if (w_any_open) begin
                        w_state_nxt = ST_REF_START;
                        w_cmd_nxt   = CMD_PREA;
                        w_cnt_nxt   = C_LD_RP;
                    end else begin
                        w_issue_ref = 1'b1;
                    end
                end else if (w_grant) begin
                    w_state_nxt = ST_DECIDE;
                    w_bank_nxt  = w_req_bank;
                    case (w_lookup)
                        LOOKUP_HIT: begin
                            w_cmd_nxt  = w_grant_wr ? CMD_WR : CMD_RD;
                            w_addr_nxt = C_ROW_WIDTH'(w_req_col);
                            w_cnt_nxt  = C_LD_CCD;
                        end
                        LOOKUP_CLOSED: begin
                            w_cmd_nxt  = CMD_ACT;
                            w_addr_nxt = w_req_row;
                            w_cnt_nxt  = C_LD_RCD;
                        end
                        default: begin
                            w_cmd_nxt  = CMD_PRE;
                            w_cnt_nxt  = C_LD_RP;
                        end
                    endcase
                end
            end
            ST_DECIDE: begin
                case (r_path)
                    LOOKUP_HIT:    w_state_nxt = w_cnt_zero ? ST_IDLE : ST_WAIT_CCD;
                    LOOKUP_CLOSED: begin
                        if (w_cnt_zero) w_issue_col = 1'b1;
                        else            w_state_nxt = ST_WAIT_RCD;
                    end
                    default: begin
                        if (w_cnt_zero) w_issue_act = 1'b1;
                        else            w_state_nxt = ST_WAIT_RP;
                    end
                endcase
            end
            ST_WAIT_RP:   if (w_cnt_zero) w_issue_act = 1'b1;
            ST_ACTIVATE: begin
                if (w_cnt_zero) w_issue_col = 1'b1;
                else            w_state_nxt = ST_WAIT_RCD;
            end
            ST_WAIT_RCD:  if (w_cnt_zero) w_issue_col = 1'b1;
            ST_ACCESS:    w_state_nxt = w_cnt_zero ? ST_IDLE : ST_WAIT_CCD;
            ST_WAIT_CCD:  if (w_cnt_zero) w_state_nxt = ST_IDLE;
            ST_REF_START: begin
                if (w_cnt_zero) w_issue_ref = 1'b1;
                else            w_state_nxt = ST_WAIT_PREA;
            end
            ST_WAIT_PREA: if (w_cnt_zero) w_issue_ref = 1'b1;
            ST_REFRESH:   w_state_nxt = w_cnt_zero ? ST_IDLE : ST_WAIT_RFC;
            ST_WAIT_RFC:  if (w_cnt_zero) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase

        if (w_issue_act) begin
            w_state_nxt = ST_ACTIVATE;
            w_cmd_nxt   = CMD_ACT;
            w_bank_nxt  = r_bank;
            w_addr_nxt  = r_row;
            w_cnt_nxt   = C_LD_RCD;
        end
        if (w_issue_col) begin
            w_state_nxt = ST_ACCESS;
            w_cmd_nxt   = r_is_write ? CMD_WR : CMD_RD;
            w_bank_nxt  = r_bank;
            w_addr_nxt  = C_ROW_WIDTH'(r_col);
            w_cnt_nxt   = C_LD_CCD;
        end
        if (w_issue_ref) begin
            w_state_nxt = ST_REFRESH;
            w_cmd_nxt   = CMD_REF;
            w_cnt_nxt   = C_LD_RFC;
        end
    end

    always_ff @(posedge core_clk or posedge core_arst) begin
        if (core_arst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bank       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_is_write   <= 1'b0;
            r_path       <= LOOKUP_CLOSED;
            r_last_grant <= GRANT_WRITE;
            r_cmd_valid  <= 1'b0;
            r_cmd_type   <= CMD_NOP;
            r_cmd_bank   <= '0;
            r_cmd_addr   <= '0;
            r_ref_do     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_valid <= (w_cmd_nxt != CMD_NOP);
            r_cmd_type  <= w_cmd_nxt;
            r_cmd_bank  <= w_bank_nxt;
            r_cmd_addr  <= w_addr_nxt;
            r_ref_do    <= (w_cmd_nxt == CMD_REF);
            if (w_grant) begin
                r_bank       <= w_req_bank;
                r_row        <= w_req_row;
                r_col        <= w_req_col;
                r_is_write   <= w_grant_wr;
                r_path       <= w_lookup;
                r_last_grant <= w_grant_wr ? GRANT_WRITE : GRANT_READ;
            end
        end
    end

    assign rd_ready  = w_grant_rd;
    assign wr_ready  = w_grant_wr;
    assign ref_do    = r_ref_do;
    assign cmd_valid = r_cmd_valid;
    assign cmd_type  = r_cmd_type;
    assign cmd_bank  = r_cmd_bank;
    assign cmd_addr  = r_cmd_addr;
    assign busy      = !w_idle;

endmodule

// File: tb/tb_ddrx_cmd_scheduler.sv
// Directed bench for ddrx_cmd_scheduler: closed/hit/conflict access timing,
// refresh with an open bank, reset mid-operation and round-robin arbitration.
module tb_ddrx_cmd_scheduler;
    import ddrx_pkg::*;

    logic        core_clk;
    logic        core_arst;
    logic        rd_valid, rd_ready;
    logic [2:0]  rd_bank;
    logic [15:0] rd_row;
    logic [11:0] rd_col;
    logic        wr_valid, wr_ready;
    logic [2:0]  wr_bank;
    logic [15:0] wr_row;
    logic [11:0] wr_col;
    logic        ref_req, ref_do;
    logic        cmd_valid;
    cmd_e        cmd_type;
    logic [2:0]  cmd_bank;
    logic [15:0] cmd_addr;
    logic        busy;

    int nVectors;
    int nMiscompares;

    logic        rrRd   [16];
    logic        rrWr   [16];
    cmd_e        rrType [16];
    logic [2:0]  rrBank [16];
    logic [15:0] rrAddr [16];

    ddrx_cmd_scheduler #(
        .C_BANK_WIDTH (3),
        .C_ROW_WIDTH  (16),
        .C_COL_WIDTH  (12),
        .C_T_RCD      (3),
        .C_T_RP       (3),
        .C_T_RFC      (8),
        .C_T_CCD      (2)
    ) dut (
        .core_clk  (core_clk),
        .core_arst (core_arst),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_bank   (rd_bank),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_bank   (wr_bank),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .ref_req   (ref_req),
        .ref_do    (ref_do),
        .cmd_valid (cmd_valid),
        .cmd_type  (cmd_type),
        .cmd_bank  (cmd_bank),
        .cmd_addr  (cmd_addr),
        .busy      (busy)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // Inputs change 1 time unit after the rising edge and are sampled a
    // further unit later, well clear of the next edge.
    task automatic applyStimulus(input logic rv, input logic [2:0] rb, input logic [15:0] rr,
                                 input logic [11:0] rc, input logic wv, input logic [2:0] wb,
                                 input logic [15:0] wrw, input logic [11:0] wc, input logic rq);
        @(posedge core_clk);
        #1;
        rd_valid = rv; rd_bank = rb; rd_row = rr; rd_col = rc;
        wr_valid = wv; wr_bank = wb; wr_row = wrw; wr_col = wc;
        ref_req  = rq;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 3'd0, 16'h0, 12'h0, 1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVectors++;
        assert (observed === expected)
        else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCycle(input string tag, input logic eRd, input logic eWr, input logic eRef,
                              input cmd_e eType, input logic [2:0] eBank, input logic [15:0] eAddr);
        logic [25:0] obs;
        logic [25:0] exp;
        obs = {rd_ready, wr_ready, ref_do, cmd_valid, cmd_type, cmd_bank, cmd_addr};
        exp = {eRd, eWr, eRef, (eType != CMD_NOP), eType, eBank, eAddr};
        checkOutput(tag, 32'(obs), 32'(exp));
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        core_arst = 1'b1;
        rd_valid = 1'b0; rd_bank = '0; rd_row = '0; rd_col = '0;
        wr_valid = 1'b0; wr_bank = '0; wr_row = '0; wr_col = '0;
        ref_req  = 1'b0;

        rrRd   = '{0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,0};
        rrWr   = '{0,0,0,0,0,1,0,0,0,0,0,0,0,0,1,0};
        rrType = '{CMD_ACT, CMD_NOP, CMD_NOP, CMD_RD, CMD_NOP, CMD_NOP, CMD_ACT, CMD_NOP,
                   CMD_NOP, CMD_WR, CMD_NOP, CMD_NOP, CMD_RD, CMD_NOP, CMD_NOP, CMD_WR};
        rrBank = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0,
                   3'd0, 3'd3, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd3};
        rrAddr = '{16'h0001, 16'h0, 16'h0, 16'h0010, 16'h0, 16'h0, 16'h0002, 16'h0,
                   16'h0, 16'h0020, 16'h0, 16'h0, 16'h0010, 16'h0, 16'h0, 16'h0020};

        // Reset: outputs idle, ready held low even with requests pending
        applyStimulus(1'b1, 3'd2, 16'h0010, 12'h008, 1'b1, 3'd1, 16'h0001, 12'h001, 1'b0);
        checkCycle("reset_outputs", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 3'd0, 16'h0, 12'h0, 1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        core_arst = 1'b0;
        idleCycle();
        checkCycle("idle_after_reset", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);

        // Closed bank read
        applyStimulus(1'b1, 3'd2, 16'h0010, 12'h008, 1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        checkCycle("closed_accept", 1, 0, 0, CMD_NOP, 3'd0, 16'h0);
        idleCycle();
        checkCycle("closed_act", 0, 0, 0, CMD_ACT, 3'd2, 16'h0010);
        checkOutput("closed_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 2; i++) begin
            idleCycle();
            checkCycle("closed_trcd_gap", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);
        end
        idleCycle();
        checkCycle("closed_rd", 0, 0, 0, CMD_RD, 3'd2, 16'h0008);
        applyStimulus(1'b1, 3'd2, 16'h0010, 12'h020, 1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        checkCycle("closed_tccd_block", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);

        // Row hit: accepted at RD+2, column command the next cycle
        applyStimulus(1'b1, 3'd2, 16'h0010, 12'h020, 1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        checkCycle("hit_accept", 1, 0, 0, CMD_NOP, 3'd0, 16'h0);
        idleCycle();
        checkCycle("hit_rd", 0, 0, 0, CMD_RD, 3'd2, 16'h0020);
        idleCycle();
        checkCycle("hit_tccd", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);

        // Row conflict write on bank 2
        applyStimulus(1'b0, 3'd0, 16'h0, 12'h0, 1'b1, 3'd2, 16'h0044, 12'h004, 1'b0);
        checkCycle("conflict_accept", 0, 1, 0, CMD_NOP, 3'd0, 16'h0);
        idleCycle();
        checkCycle("conflict_pre", 0, 0, 0, CMD_PRE, 3'd2, 16'h0);
        for (int i = 0; i < 2; i++) begin
            idleCycle();
            checkCycle("conflict_trp_gap", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);
        end
        idleCycle();
        checkCycle("conflict_act", 0, 0, 0, CMD_ACT, 3'd2, 16'h0044);
        for (int i = 0; i < 2; i++) begin
            idleCycle();
            checkCycle("conflict_trcd_gap", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);
        end
        idleCycle();
        checkCycle("conflict_wr", 0, 0, 0, CMD_WR, 3'd2, 16'h0004);

        // Refresh with bank 2 open; ref_req is ignored during WAIT_CCD
        applyStimulus(1'b1, 3'd2, 16'h0044, 12'h001, 1'b0, 3'd0, 16'h0, 12'h0, 1'b1);
        checkCycle("ref_ignored_busy", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);
        applyStimulus(1'b1, 3'd2, 16'h0044, 12'h001, 1'b0, 3'd0, 16'h0, 12'h0, 1'b1);
        checkCycle("ref_wins_idle", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);
        applyStimulus(1'b1, 3'd2, 16'h0044, 12'h001, 1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        checkCycle("ref_prea", 0, 0, 0, CMD_PREA, 3'd0, 16'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 3'd2, 16'h0044, 12'h001, 1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
            checkCycle("ref_trp_gap", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);
        end
        applyStimulus(1'b1, 3'd2, 16'h0044, 12'h001, 1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        checkCycle("ref_issue", 0, 0, 1, CMD_REF, 3'd0, 16'h0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 3'd2, 16'h0044, 12'h001, 1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
            checkCycle("ref_trfc_hold", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);
        end
        applyStimulus(1'b1, 3'd2, 16'h0044, 12'h001, 1'b0, 3'd0, 16'h0, 12'h0, 1'b0);
        checkCycle("ref_pending_accept", 1, 0, 0, CMD_NOP, 3'd0, 16'h0);
        idleCycle();
        checkCycle("ref_table_cleared_act", 0, 0, 0, CMD_ACT, 3'd2, 16'h0044);
        for (int i = 0; i < 2; i++) begin
            idleCycle();
        end
        idleCycle();
        checkCycle("ref_followup_rd", 0, 0, 0, CMD_RD, 3'd2, 16'h0001);
        idleCycle();

        // Reset the cycle after a PRE: no ACT follows, and the resent request sees a closed bank
        applyStimulus(1'b0, 3'd0, 16'h0, 12'h0, 1'b1, 3'd2, 16'h0055, 12'h003, 1'b0);
        checkCycle("rst_mid_accept", 0, 1, 0, CMD_NOP, 3'd0, 16'h0);
        applyStimulus(1'b0, 3'd0, 16'h0, 12'h0, 1'b1, 3'd2, 16'h0055, 12'h003, 1'b0);
        checkCycle("rst_mid_pre", 0, 0, 0, CMD_PRE, 3'd2, 16'h0);
        applyStimulus(1'b0, 3'd0, 16'h0, 12'h0, 1'b1, 3'd2, 16'h0055, 12'h003, 1'b0);
        checkOutput("rst_mid_busy_before", 32'(busy), 32'd1);
        core_arst = 1'b1;
        #1;
        checkOutput("rst_mid_busy_async", 32'(busy), 32'd0);
        checkCycle("rst_mid_outputs", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'd0, 16'h0, 12'h0, 1'b1, 3'd2, 16'h0055, 12'h003, 1'b0);
            checkCycle("rst_mid_no_act", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);
        end
        core_arst = 1'b0;
        #1;
        checkCycle("rst_mid_resend_accept", 0, 1, 0, CMD_NOP, 3'd0, 16'h0);
        idleCycle();
        checkCycle("rst_mid_resend_act", 0, 0, 0, CMD_ACT, 3'd2, 16'h0055);
        for (int i = 0; i < 2; i++) begin
            idleCycle();
        end
        idleCycle();
        checkCycle("rst_mid_resend_wr", 0, 0, 0, CMD_WR, 3'd2, 16'h0003);

        // Round robin with both requesters held high from reset
        applyStimulus(1'b1, 3'd1, 16'h0001, 12'h010, 1'b1, 3'd3, 16'h0002, 12'h020, 1'b0);
        core_arst = 1'b1;
        #1;
        checkCycle("rr_in_reset", 0, 0, 0, CMD_NOP, 3'd0, 16'h0);
        applyStimulus(1'b1, 3'd1, 16'h0001, 12'h010, 1'b1, 3'd3, 16'h0002, 12'h020, 1'b0);
        core_arst = 1'b0;
        #1;
        checkCycle("rr_first_read", 1, 0, 0, CMD_NOP, 3'd0, 16'h0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 3'd1, 16'h0001, 12'h010, 1'b1, 3'd3, 16'h0002, 12'h020, 1'b0);
            checkCycle($sformatf("rr_cycle%0d", i + 1), rrRd[i], rrWr[i], 1'b0, rrType[i], rrBank[i], rrAddr[i]);
        end

        idleCycle();
        idleCycle();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
